// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and the MEM stage.
// MEM has priority; each access holds the command for LATENCY cycles, then pulses ready.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        halt_in,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             halt_flag;

    logic mem_req;
    logic grant_mem;
    logic grant_if;
    logic busy;
    logic access_done;

    assign mem_req     = mem_read | mem_write;
    assign grant_mem   = (state == IDLE) && mem_req;
    assign grant_if    = (state == IDLE) && !mem_req && if_req && !halt_flag;
    assign busy        = (state == BUSY_IF) || (state == BUSY_MEM);
    assign access_done = busy && (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_nxt = BUSY_MEM;
                end else if (grant_if) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command, counter and result registers; ready pulses last exactly the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            halt_flag <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (halt_in) begin
                halt_flag <= 1'b1;
            end
            if (grant_mem) begin
                ram_en    <= 1'b1;
                ram_we    <= mem_write;
                ram_addr  <= mem_addr;
                ram_wdata <= mem_wdata;
                cnt       <= CNT_LOAD;
            end else if (grant_if) begin
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= if_addr;
                cnt      <= CNT_LOAD;
            end else if (busy && !access_done) begin
                cnt <= cnt - CNT_W'(1);
            end else if (access_done) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                if (state == BUSY_IF) begin
                    if_rdata <= ram_rdata;
                    if_ready <= 1'b1;
                end else begin
                    // Stores complete without disturbing the last load result.
                    if (!ram_we) begin
                        mem_rdata <= ram_rdata;
                    end
                    mem_ready <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_mem = mem_req & ~mem_ready;
        stall_if  = (if_req & ~if_ready) | halt_flag;
        halted    = halt_flag & (state == IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LATENCY=2 instance (a_*) and LATENCY=1 instance (b_*).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t qa_if[$];
    exp_t qa_mem[$];
    exp_t qb_mem[$];

    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: rom = 32'hA0A0_A0A0;
            32'h0000_0004: rom = 32'hB1B1_B1B1;
            32'h0000_0040: rom = 32'h8C01_0004;
            32'h0000_0044: rom = 32'h0022_1820;
            32'h0000_0200: rom = 32'hCAFE_F00D;
            32'h0000_0204: rom = 32'h1234_5678;
            default:       rom = 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- DUT A, LATENCY=2 ----------------
    logic        a_rst_n = 1'b0;
    logic        a_if_req = 1'b0, a_mem_read = 1'b0, a_mem_write = 1'b0, a_halt_in = 1'b0;
    logic [31:0] a_if_addr = '0, a_mem_addr = '0, a_mem_wdata = '0;
    logic [31:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic        a_if_ready, a_mem_ready, a_ram_en, a_ram_we, a_stall_if, a_stall_mem, a_halted;

    assign a_ram_rdata = a_ram_en ? rom(a_ram_addr) : 32'hBAD0_BAD0;

    mem_port_arbiter #(.LATENCY(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ready(a_mem_ready),
        .halt_in(a_halt_in), .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .stall_if(a_stall_if), .stall_mem(a_stall_mem), .halted(a_halted)
    );

    // ---------------- DUT B, LATENCY=1 ----------------
    logic        b_rst_n = 1'b0;
    logic        b_if_req = 1'b0, b_mem_read = 1'b0, b_mem_write = 1'b0, b_halt_in = 1'b0;
    logic [31:0] b_if_addr = '0, b_mem_addr = '0, b_mem_wdata = '0;
    logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic        b_if_ready, b_mem_ready, b_ram_en, b_ram_we, b_stall_if, b_stall_mem, b_halted;

    assign b_ram_rdata = b_ram_en ? rom(b_ram_addr) : 32'hBAD0_BAD0;

    mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
        .halt_in(b_halt_in), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem), .halted(b_halted)
    );

    // ---------------- Monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (a_if_ready) begin
            if (qa_if.size() == 0) begin
                check("a_if_ready_unexpected", 32'd1, 32'd0);
            end else begin
                e = qa_if.pop_front();
                check("a_if_rdata", a_if_rdata, e.data);
                check("a_if_ready_cycle", 32'(cyc), 32'(e.at));
            end
        end
        if (a_mem_ready) begin
            if (qa_mem.size() == 0) begin
                check("a_mem_ready_unexpected", 32'd1, 32'd0);
            end else begin
                e = qa_mem.pop_front();
                check("a_mem_rdata", a_mem_rdata, e.data);
                check("a_mem_ready_cycle", 32'(cyc), 32'(e.at));
            end
        end
        if (b_if_ready) begin
            check("b_if_ready_unexpected", 32'd1, 32'd0);
        end
        if (b_mem_ready) begin
            if (qb_mem.size() == 0) begin
                check("b_mem_ready_unexpected", 32'd1, 32'd0);
            end else begin
                e = qb_mem.pop_front();
                check("b_mem_rdata", b_mem_rdata, e.data);
                check("b_mem_ready_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_fetch(input logic [31:0] addr, input logic [31:0] exp_data, input int delay);
        bit got = 0;
        a_if_req  = 1'b1;
        a_if_addr = addr;
        qa_if.push_back('{exp_data, cyc + delay});
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = a_if_ready;
        end
        if (!got) check("a_if_timeout", 32'd0, 32'd1);
        next_cycle(1);
        a_if_req = 1'b0;
    endtask

    task automatic a_mem(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_data, input int delay);
        bit got = 0;
        a_mem_read  = rd;
        a_mem_write = wr;
        a_mem_addr  = addr;
        a_mem_wdata = wdata;
        qa_mem.push_back('{exp_data, cyc + delay});
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = a_mem_ready;
        end
        if (!got) check("a_mem_timeout", 32'd0, 32'd1);
        next_cycle(1);
        a_mem_read  = 1'b0;
        a_mem_write = 1'b0;
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        int t0;
        next_cycle(2);
        check("a_reset_ram_en", 32'(a_ram_en), 32'd0);
        check("a_reset_ram_addr", a_ram_addr, 32'd0);
        check("a_reset_if_rdata", a_if_rdata, 32'd0);
        check("a_reset_halted", 32'(a_halted), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        next_cycle(2);

        // Fetch at 0x40: busy cycles 1-2, ready in cycle 3, stall_if cycles 0-2.
        t0 = cyc;
        a_if_req  = 1'b1;
        a_if_addr = 32'h40;
        qa_if.push_back('{32'h8C01_0004, t0 + 3});
        #1 check("f_c0_stall_if", 32'(a_stall_if), 32'd1);
        check("f_c0_ram_en", 32'(a_ram_en), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle(1);
            #1;
            check("f_busy_ram_en", 32'(a_ram_en), 32'd1);
            check("f_busy_ram_we", 32'(a_ram_we), 32'd0);
            check("f_busy_ram_addr", a_ram_addr, 32'h40);
            check("f_busy_stall_if", 32'(a_stall_if), 32'd1);
        end
        next_cycle(1);
        #1 check("f_done_ram_en", 32'(a_ram_en), 32'd0);
        check("f_done_stall_if", 32'(a_stall_if), 32'd0);
        next_cycle(1);
        a_if_req = 1'b0;
        next_cycle(1);

        // Load 0x200 so a later store can be seen to leave mem_rdata alone.
        a_mem(1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 3);
        next_cycle(1);

        // Store 0x100: command held two cycles, mem_rdata keeps the prior load value.
        fork
            a_mem(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'hCAFE_F00D, 3);
            begin
                #1 check("s_c0_stall_mem", 32'(a_stall_mem), 32'd1);
                for (int c = 1; c <= 2; c++) begin
                    next_cycle(1);
                    #1;
                    check("s_busy_ram_en", 32'(a_ram_en), 32'd1);
                    check("s_busy_ram_we", 32'(a_ram_we), 32'd1);
                    check("s_busy_ram_addr", a_ram_addr, 32'h100);
                    check("s_busy_ram_wdata", a_ram_wdata, 32'hDEAD_BEEF);
                    check("s_busy_stall_mem", 32'(a_stall_mem), 32'd1);
                end
                next_cycle(1);
                #1 check("s_done_ram_we", 32'(a_ram_we), 32'd0);
                check("s_done_stall_mem", 32'(a_stall_mem), 32'd0);
            end
        join
        next_cycle(1);

        // Simultaneous load and fetch: MEM ready in cycle 3, IF granted cycle 4, ready cycle 7.
        fork
            a_mem(1'b1, 1'b0, 32'h204, 32'h0, 32'h1234_5678, 3);
            a_fetch(32'h44, 32'h0022_1820, 7);
            begin
                next_cycle(1);
                #1 check("arb_mem_first_addr", a_ram_addr, 32'h204);
                check("arb_stall_if_while_mem", 32'(a_stall_if), 32'd1);
            end
        join
        next_cycle(1);

        // Reset in busy cycle 1 of a fetch: command drops immediately, no ready pulse.
        a_if_req  = 1'b1;
        a_if_addr = 32'h40;
        next_cycle(1);
        check("rst_pre_ram_en", 32'(a_ram_en), 32'd1);
        a_rst_n = 1'b0;
        #1 check("rst_async_ram_en", 32'(a_ram_en), 32'd0);
        check("rst_async_ram_addr", a_ram_addr, 32'd0);
        a_if_req = 1'b0;
        next_cycle(1);
        a_rst_n = 1'b1;
        next_cycle(4);
        check("rst_after_ram_en", 32'(a_ram_en), 32'd0);
        a_fetch(32'h40, 32'h8C01_0004, 3);
        next_cycle(1);

        // Halt during BUSY_IF: in-flight fetch completes, later fetches ignored, loads served.
        t0 = cyc;
        a_if_req  = 1'b1;
        a_if_addr = 32'h44;
        qa_if.push_back('{32'h0022_1820, t0 + 3});
        next_cycle(1);
        a_halt_in = 1'b1;
        next_cycle(1);
        a_halt_in = 1'b0;
        #1 check("h_busy_halted", 32'(a_halted), 32'd0);
        next_cycle(2);
        #1 check("h_idle_halted", 32'(a_halted), 32'd1);
        check("h_idle_stall_if", 32'(a_stall_if), 32'd1);
        check("h_idle_ram_en", 32'(a_ram_en), 32'd0);
        next_cycle(2);
        check("h_no_grant_ram_en", 32'(a_ram_en), 32'd0);
        a_mem(1'b1, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D, 3);
        #1 check("h_after_load_halted", 32'(a_halted), 32'd1);
        check("h_after_load_ram_en", 32'(a_ram_en), 32'd0);
        a_if_req = 1'b0;
        #1 check("h_stall_if_sticky", 32'(a_stall_if), 32'd1);
        next_cycle(2);

        // LATENCY=1 back-to-back loads: ready in cycles 2 and 5, nothing issued in DONE.
        t0 = cyc;
        b_mem_read = 1'b1;
        b_mem_addr = 32'h0;
        qb_mem.push_back('{32'hA0A0_A0A0, t0 + 2});
        next_cycle(1);
        #1 check("b_c1_ram_en", 32'(b_ram_en), 32'd1);
        check("b_c1_stall_mem", 32'(b_stall_mem), 32'd1);
        next_cycle(1);
        #1 check("b_c2_no_reissue", 32'(b_ram_en), 32'd0);
        check("b_c2_stall_mem", 32'(b_stall_mem), 32'd0);
        next_cycle(1);
        b_mem_addr = 32'h4;
        qb_mem.push_back('{32'hB1B1_B1B1, t0 + 5});
        next_cycle(1);
        #1 check("b_c4_ram_addr", b_ram_addr, 32'h4);
        check("b_c4_ram_en", 32'(b_ram_en), 32'd1);
        next_cycle(1);
        #1 check("b_c5_ram_en", 32'(b_ram_en), 32'd0);
        next_cycle(1);
        b_mem_read = 1'b0;
        next_cycle(3);
        check("b_idle_ram_en", 32'(b_ram_en), 32'd0);

        check("a_if_queue_drained", 32'(qa_if.size()), 32'd0);
        check("a_mem_queue_drained", 32'(qa_mem.size()), 32'd0);
        check("b_mem_queue_drained", 32'(qb_mem.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
